// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    // Width of the iteration counter that runs from N-1 down to 0.
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ks_subtractor.sv
// Kogge-Stone parallel-prefix subtractor: diff = a - b, computed as a + ~b + 1.
module ks_subtractor #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    localparam int LEVELS = $clog2(W);

    logic [W-1:0] p0;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W:0]   c;

    // NOTE: combinational blocks use blocking '=' so each prefix level sees
    // the previous level's result within the same evaluation.
    always_comb begin
        p0 = a ^ ~b;
        g  = a & ~b;
        p  = p0;
        gn = '0;
        pn = '0;
        for (int l = 0; l < LEVELS; l++) begin
            gn = g;
            pn = p;
            for (int i = 1; i < W; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    pn[i] = p[i] & p[i - (1 << l)];
                end
            end
            g = gn;
            p = pn;
        end
        // Carry-in is fixed at 1, so every group carry is simply G | P.
        c[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            c[i + 1] = g[i] | p[i];
        end
        diff   = p0 ^ c[W-1:0];
        borrow = ~c[W];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional SEQ_DIV_DZ_EN: zero divisor short-cuts to DONE and flags div_by_zero.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy
`ifdef SEQ_DIV_DZ_EN
    ,
    output logic         div_by_zero
`endif
);

    localparam int CW = cnt_width(N);

    state_t        state;
    state_t        state_n;
    logic [N-1:0]  q;
    logic [N:0]    r;
    logic [N-1:0]  d;
    logic [CW-1:0] count;
    logic [N:0]    s;
    logic [N:0]    t;
    logic          borrow;
    logic          unused_r_msb;

`ifdef SEQ_DIV_DZ_EN
    logic dz;
    logic zero_div;
    assign zero_div    = (divisor == '0);
    assign div_by_zero = dz;
`else
    logic zero_div;
    assign zero_div = 1'b0;
`endif

    assign s = {r[N-1:0], q[N-1]};
    // The top bit of R is always zero after a restoring step.
    assign unused_r_msb = r[N];

    ks_subtractor #(.W(N + 1)) u_sub (
        .a      (s),
        .b      ({1'b0, d}),
        .diff   (t),
        .borrow (borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // NOTE: state_n takes a default before the case so no path infers a latch.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (in_valid)   state_n = zero_div ? DONE : CALC;
            CALC: if (count == '0) state_n = DONE;
            DONE: if (out_ready)  state_n = IDLE;
            default:              state_n = IDLE;
        endcase
    end

    // NOTE: d and count are loaded at every accept before they are read,
    // so only the registers that are visible on the outputs are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
            r <= '0;
`ifdef SEQ_DIV_DZ_EN
            dz <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        q     <= dividend;
                        r     <= '0;
                        d     <= divisor;
                        count <= CW'(N - 1);
`ifdef SEQ_DIV_DZ_EN
                        if (zero_div) begin
                            q  <= '1;
                            r  <= {1'b0, dividend};
                            dz <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
                    r     <= borrow ? s : t;
                    q     <= {q[N-2:0], ~borrow};
                    count <= count - CW'(1);
                end
                DONE: begin
`ifdef SEQ_DIV_DZ_EN
                    if (out_ready) dz <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);
    assign quotient  = q;
    assign remainder = r[N-1:0];

endmodule
